// File: rtl/grad_weight_mult_pipe.sv
// grad_weight_mult_pipe: multiplies NCH signed colour-difference samples by one
// shared unsigned gradient weight, then shifts (optionally rounding half-up)
// and fits each product to OUT_W bits.
// Pipeline: S1 input capture -> S2 product -> S3 shift/round/fit -> output reg.
// Each register loads when empty or when it drains in the same cycle.
// Ports:
//   clk, rst (async assert, active-low)
//   in_valid/in_ready, grad[GRAD_W], g_m_rb[NCH*DATA_W], rnd_en : input beat
//   out_valid/out_ready, rb_deriv[NCH*OUT_W]                    : result beat
//   sat_clr, sat_flag[NCH] : sticky saturation flags
// Build option: define GRAD_WEIGHT_SAT_EN to clamp out-of-range results and
// drive sat_flag; otherwise results wrap and sat_flag is tied to 0.
module grad_weight_mult_pipe #(
    parameter int unsigned DATA_W = 14,
    parameter int unsigned GRAD_W = 8,
    parameter int unsigned NCH    = 2,
    parameter int unsigned SHIFT  = GRAD_W,
    parameter int unsigned OUT_W  = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [GRAD_W-1:0]       grad,
    input  logic [NCH*DATA_W-1:0]   g_m_rb,
    input  logic                    rnd_en,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [NCH*OUT_W-1:0]    rb_deriv,
    input  logic                    sat_clr,
    output logic [NCH-1:0]          sat_flag
);

    localparam int unsigned PROD_W = DATA_W + GRAD_W + 1;
    // Working width: room for the rounding add and for sign-extension to OUT_W.
    localparam int unsigned BIG_W  = (((PROD_W + 1) > OUT_W) ? (PROD_W + 1) : OUT_W) + 1;
    localparam int unsigned RND_SH = (SHIFT > 0) ? (SHIFT - 1) : 0;
    localparam logic [BIG_W-1:0] RND_K = (SHIFT > 0) ? (BIG_W'(1) << RND_SH) : BIG_W'(0);

    // Stage registers
    logic                           r_run;
    logic                           r_s1_v, r_s2_v, r_s3_v, r_ov;
    logic                           r_s1_rnd, r_s2_rnd;
    logic [GRAD_W-1:0]              r_s1_grad;
    logic signed [DATA_W-1:0]       r_s1_smp [NCH];
    logic signed [PROD_W-1:0]       r_s2_prod [NCH];
    logic [NCH-1:0][OUT_W-1:0]      r_s3_res;
    logic [NCH-1:0][OUT_W-1:0]      r_out;

    // Combinational datapath
    logic signed [PROD_W-1:0]       w_prod [NCH];
    logic [BIG_W-1:0]               w_sum;
    logic [NCH-1:0][BIG_W-1:0]      w_sh;
    logic [NCH-1:0][OUT_W-1:0]      w_fit;
    logic                           w_ld_o, w_ld_3, w_ld_2, w_ld_1, w_acc;
    logic                           w_unused_sh;

    // Load-enable chain: a stage loads when empty or when it drains this cycle
    assign w_ld_o   = !r_ov   || out_ready;
    assign w_ld_3   = !r_s3_v || w_ld_o;
    assign w_ld_2   = !r_s2_v || w_ld_3;
    assign w_ld_1   = !r_s1_v || w_ld_2;
    assign in_ready = r_run && w_ld_1;
    assign w_acc    = in_valid && in_ready;

    assign out_valid = r_ov;
    assign rb_deriv  = r_out;
    assign w_unused_sh = ^w_sh;

    // Products: signed sample times zero-extended weight, full width
    always_comb begin
        for (int ch = 0; ch < NCH; ch++) begin
            w_prod[ch] = PROD_W'(r_s1_smp[ch]) * PROD_W'($signed({1'b0, r_s1_grad}));
        end
    end

`ifdef GRAD_WEIGHT_SAT_EN
    localparam logic [BIG_W-1:0] O_MAX = (BIG_W'(1) << (OUT_W - 1)) - BIG_W'(1);
    localparam logic [BIG_W-1:0] O_MIN = ~O_MAX;
    logic [NCH-1:0] w_ovf;
    logic [NCH-1:0] r_s3_sat;
    logic [NCH-1:0] r_sat;
`else
    logic w_unused_sat_clr;
    assign w_unused_sat_clr = sat_clr;
`endif

    // Round, arithmetic shift and fit to OUT_W
    always_comb begin
        w_sum = '0;
        w_sh  = '0;
        w_fit = '0;
`ifdef GRAD_WEIGHT_SAT_EN
        w_ovf = '0;
`endif
        for (int ch = 0; ch < NCH; ch++) begin
            w_sum    = BIG_W'(r_s2_prod[ch]) + (r_s2_rnd ? RND_K : BIG_W'(0));
            w_sh[ch] = $signed(w_sum) >>> SHIFT;
`ifdef GRAD_WEIGHT_SAT_EN
            if ($signed(w_sh[ch]) > $signed(O_MAX)) begin
                w_fit[ch] = O_MAX[OUT_W-1:0];
                w_ovf[ch] = 1'b1;
            end else if ($signed(w_sh[ch]) < $signed(O_MIN)) begin
                w_fit[ch] = O_MIN[OUT_W-1:0];
                w_ovf[ch] = 1'b1;
            end else begin
                w_fit[ch] = w_sh[ch][OUT_W-1:0];
            end
`else
            w_fit[ch] = w_sh[ch][OUT_W-1:0];
`endif
        end
    end

    // Pipeline registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_run     <= 1'b0;
            r_s1_v    <= 1'b0;
            r_s2_v    <= 1'b0;
            r_s3_v    <= 1'b0;
            r_ov      <= 1'b0;
            r_s1_rnd  <= 1'b0;
            r_s2_rnd  <= 1'b0;
            r_s1_grad <= '0;
            r_s3_res  <= '0;
            r_out     <= '0;
            for (int ch = 0; ch < NCH; ch++) begin
                r_s1_smp[ch]  <= '0;
                r_s2_prod[ch] <= '0;
            end
        end else begin
            r_run <= 1'b1;
            if (w_ld_1) begin
                r_s1_v <= w_acc;
                if (w_acc) begin
                    r_s1_rnd  <= rnd_en;
                    r_s1_grad <= grad;
                    for (int ch = 0; ch < NCH; ch++) begin
                        r_s1_smp[ch] <= g_m_rb[ch*DATA_W +: DATA_W];
                    end
                end
            end
            if (w_ld_2) begin
                r_s2_v <= r_s1_v;
                if (r_s1_v) begin
                    r_s2_rnd <= r_s1_rnd;
                    for (int ch = 0; ch < NCH; ch++) begin
                        r_s2_prod[ch] <= w_prod[ch];
                    end
                end
            end
            if (w_ld_3) begin
                r_s3_v <= r_s2_v;
                if (r_s2_v) begin
                    r_s3_res <= w_fit;
                end
            end
            if (w_ld_o) begin
                r_ov <= r_s3_v;
                if (r_s3_v) begin
                    r_out <= r_s3_res;
                end
            end
        end
    end

`ifdef GRAD_WEIGHT_SAT_EN
    // Sticky saturation flags; a clamped beat entering the output register wins over clear
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_s3_sat <= '0;
            r_sat    <= '0;
        end else begin
            if (w_ld_3 && r_s2_v) begin
                r_s3_sat <= w_ovf;
            end
            r_sat <= (sat_clr ? '0 : r_sat) | ((w_ld_o && r_s3_v) ? r_s3_sat : '0);
        end
    end
    assign sat_flag = r_sat;
`else
    assign sat_flag = '0;
`endif

endmodule

// File: tb/tb_grad_weight_mult_pipe.sv
// Directed bench for grad_weight_mult_pipe: a default instance (SHIFT=8) and a
// SHIFT=0 instance share all inputs; expected values are hand-computed.
module tb_grad_weight_mult_pipe;

    localparam int unsigned DATA_W = 14;
    localparam int unsigned GRAD_W = 8;
    localparam int unsigned NCH    = 2;
    localparam int unsigned OUT_W  = 16;

`ifdef GRAD_WEIGHT_SAT_EN
    localparam int Z_BIG0 = 32767;
    localparam int Z_BIG1 = -32768;
    localparam int Z_SF   = 3;
`else
    // 8191*255 = 0x1FDF01 -> 0xDF01; -8192*255 = -0x1FE000 -> 0x2000
    localparam int Z_BIG0 = -8447;
    localparam int Z_BIG1 = 8192;
    localparam int Z_SF   = 0;
`endif

    logic                   clk = 1'b0;
    logic                   rst = 1'b0;
    logic                   in_valid = 1'b0;
    logic                   rnd_en = 1'b0;
    logic                   out_ready = 1'b1;
    logic                   sat_clr = 1'b0;
    logic [GRAD_W-1:0]      grad = '0;
    logic [NCH*DATA_W-1:0]  g_m_rb = '0;
    logic                   in_ready, out_valid, in_ready0, out_valid0;
    logic [NCH*OUT_W-1:0]   rb_deriv, rb_deriv0;
    logic [NCH-1:0]         sat_flag, sat_flag0;

    int n_vec = 0;
    int n_err = 0;
    int e0_q[$];
    int e1_q[$];
    int pops = 0;
    int gaps = 0;
    logic mon_on = 1'b0;

    always #5 clk = ~clk;

    grad_weight_mult_pipe dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .grad(grad), .g_m_rb(g_m_rb), .rnd_en(rnd_en),
        .out_valid(out_valid), .out_ready(out_ready), .rb_deriv(rb_deriv),
        .sat_clr(sat_clr), .sat_flag(sat_flag)
    );

    grad_weight_mult_pipe #(.SHIFT(0)) dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0),
        .grad(grad), .g_m_rb(g_m_rb), .rnd_en(rnd_en),
        .out_valid(out_valid0), .out_ready(out_ready), .rb_deriv(rb_deriv0),
        .sat_clr(sat_clr), .sat_flag(sat_flag0)
    );

    task automatic chk(input string tag, input int got, input int exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int res(input logic [NCH*OUT_W-1:0] v, input int ch);
        return int'($signed(v[ch*OUT_W +: OUT_W]));
    endfunction

    // Reference for SHIFT=8: (a*g [+128]) >>> 8
    function automatic int model(input int a, input int g, input logic r);
        int p;
        p = a * g;
        if (r) p = p + 128;
        return p >>> 8;
    endfunction

    task automatic set_in(input int g, input int c0, input int c1, input logic r);
        grad   = GRAD_W'(g);
        g_m_rb = {DATA_W'(c1), DATA_W'(c0)};
        rnd_en = r;
    endtask

    // Called just after a rising edge with an empty pipeline
    task automatic single(input string tag, input int g, input int c0, input int c1,
                          input logic r, input int e0, input int e1,
                          input int z0, input int z1, input int sf0);
        int lat;
        set_in(g, c0, c1, r);
        in_valid = 1'b1;
        chk({tag, "_rdy"}, int'(in_ready), 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 10) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, "_lat"}, lat, 3);
        chk({tag, "_c0"}, res(rb_deriv, 0), e0);
        chk({tag, "_c1"}, res(rb_deriv, 1), e1);
        chk({tag, "_z0"}, res(rb_deriv0, 0), z0);
        chk({tag, "_z1"}, res(rb_deriv0, 1), z1);
        chk({tag, "_sf"}, int'(sat_flag), 0);
        chk({tag, "_sf0"}, int'(sat_flag0), sf0);
        @(posedge clk); #1;
    endtask

    // Stream scoreboard
    always @(posedge clk) begin
        if (mon_on) begin
            if (out_valid && out_ready) begin
                if (e0_q.size() == 0) begin
                    chk("strm_extra", 1, 0);
                end else begin
                    chk("strm_c0", res(rb_deriv, 0), e0_q.pop_front());
                    chk("strm_c1", res(rb_deriv, 1), e1_q.pop_front());
                    pops++;
                end
            end else if (out_ready && !out_valid && pops > 0 && pops < 10) begin
                gaps++;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        int g, a, b, n, cnt;
        logic r, ok;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", int'(in_ready), 0);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_rb_deriv", int'(rb_deriv), 0);
        chk("rst_sat_flag", int'(sat_flag0), 0);
        rst = 1'b1;
        #1;
        chk("rel_in_ready_pre", int'(in_ready), 0);
        @(posedge clk); #1;
        chk("rel_in_ready", int'(in_ready), 1);

        // Single beats
        single("v100",  128,  100, -100, 1'b0,   50,   -50, 12800, -12800, 0);
        single("v3f",   128,    3,   -3, 1'b0,    1,    -2,   384,   -384, 0);
        single("v3r",   128,    3,   -3, 1'b1,    2,    -1,   384,   -384, 0);
        single("vm1f",    1,   -1,    0, 1'b0,   -1,     0,    -1,      0, 0);
        single("vm1r",    1,   -1,    0, 1'b1,    0,     0,    -1,      0, 0);
        single("vbig",  255, 8191, -8192, 1'b0, 8159, -8160, Z_BIG0, Z_BIG1, Z_SF);
        single("vstk",  128,    3,   -3, 1'b0,    1,    -2,   384,   -384, Z_SF);
        sat_clr = 1'b1;
        @(posedge clk); #1;
        sat_clr = 1'b0;
        chk("sat_clr", int'(sat_flag0), 0);

        // Ten back-to-back beats with a five-cycle output stall
        mon_on = 1'b1;
        fork
            begin
                for (int i = 0; i < 10; i++) begin
                    g = 100 + i * 10;
                    a = 37 * i - 150;
                    b = 11 - 53 * i;
                    r = 1'(i % 2);
                    set_in(g, a, b, r);
                    in_valid = 1'b1;
                    n = 0;
                    do begin
                        @(posedge clk);
                        ok = in_ready;
                        n++;
                    end while (!ok && n < 50);
                    if (!ok) chk("strm_accept", 0, 1);
                    e0_q.push_back(model(a, g, r));
                    e1_q.push_back(model(b, g, r));
                    #1;
                end
                in_valid = 1'b0;
            end
            begin
                repeat (6) @(posedge clk);
                #1 out_ready = 1'b0;
                repeat (5) @(posedge clk);
                #1;
                chk("stall_in_ready", int'(in_ready), 0);
                chk("stall_occupancy", e0_q.size(), 4);
                chk("stall_out_valid", int'(out_valid), 1);
                chk("stall_hold_c0", res(rb_deriv, 0), model(-76, 120, 1'b0));
                chk("stall_hold_c1", res(rb_deriv, 1), model(-95, 120, 1'b0));
                out_ready = 1'b1;
            end
        join
        n = 0;
        while (pops < 10 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        mon_on = 1'b0;
        chk("strm_count", pops, 10);
        chk("strm_gaps", gaps, 0);

        // Reset with beats in flight
        @(posedge clk); #1;
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            set_in(128, 20 + k, -20 - k, 1'b0);
            in_valid = 1'b1;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        @(posedge clk); #1;
        chk("rst_mid_pre_ov", int'(out_valid), 1);
        rst = 1'b0;
        #1;
        chk("rst_mid_ov", int'(out_valid), 0);
        chk("rst_mid_rdy", int'(in_ready), 0);
        chk("rst_mid_rb", int'(rb_deriv), 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("rst_mid_rel_rdy", int'(in_ready), 1);
        cnt = 0;
        repeat (6) begin
            @(posedge clk); #1;
            if (out_valid) cnt++;
        end
        chk("rst_mid_no_out", cnt, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
